divider_n_bit: RTL and testbench

//  Multi-cycle restoring integer divider; inverse operation of the ALU multiplier.

---
 rtl/divider_pkg.sv | 17 +
 rtl/divider_n_bit_if.sv | 27 ++
 rtl/divider_step.sv | 31 +++
 rtl/divider_n_bit.sv | 177 +++++++++++++++++
 tb/tb_divider_n_bit.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider.
//   state_e    : FSM state encoding (idle, iterating, result-valid)
//   cnt_width  : width of the iteration counter for a given operand width
package divider_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Counter must hold the value 'size' itself, hence size+1.
  function automatic int unsigned cnt_width(input int unsigned size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/divider_n_bit_if.sv
// Request/result bundle between an execute stage and the divider.
//   master : start, in_a (dividend), in_b (divisor) out; results in
//   slave  : the divider side; out (quotient), rem, busy, done,
//            div_by_zero, overflow out
interface divider_n_bit_if #(
  parameter int unsigned size = 4
);
  logic            start;
  logic [size-1:0] in_a;
  logic [size-1:0] in_b;
  logic [size-1:0] out;
  logic [size-1:0] rem;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic            overflow;

  modport master (
    output start, in_a, in_b,
    input  out, rem, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, in_a, in_b,
    output out, rem, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/divider_step.sv
// One restoring-division iteration, purely combinational.
//   part_rem      : partial remainder entering this step (always < divisor)
//   dividend      : remaining dividend bits, MSB consumed first
//   divisor       : non-zero divisor magnitude
//   next_rem      : partial remainder after the trial subtract / restore
//   next_dividend : dividend shifted left with the new quotient bit in the LSB
module divider_step #(
  parameter int unsigned size = 4
) (
  input  logic [size-1:0] part_rem,
  input  logic [size-1:0] dividend,
  input  logic [size-1:0] divisor,
  output logic [size-1:0] next_rem,
  output logic [size-1:0] next_dividend
);

  logic [size:0]   shifted;
  logic [size-1:0] trial;
  logic            q_bit;

  always_comb begin
    shifted = {part_rem, dividend[size-1]};
    q_bit   = (shifted >= {1'b0, divisor});
    // When no borrow occurs the difference is below the divisor, so the low
    // size bits of a modular subtract are exact.
    trial         = shifted[size-1:0] - divisor;
    next_rem      = q_bit ? trial : shifted[size-1:0];
    next_dividend = {dividend[size-2:0], q_bit};
  end

endmodule

// File: rtl/divider_n_bit.sv
// Multi-cycle restoring integer divider (one quotient bit per clock).
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : divider_n_bit_if slave port (start/in_a/in_b in;
//              out/rem/busy/done/div_by_zero/overflow out)
// A start seen in idle or done captures the operands; the quotient and
// remainder appear size+1 cycles later together with a one-cycle done.
// Division by zero skips iteration and completes in one cycle.
// Optional feature macro: DIVIDER_SIGNED_EN selects two's-complement operands
// (magnitudes are divided, then the result signs are fixed up on completion).
module divider_n_bit
  import divider_pkg::*;
#(
  parameter int unsigned size = 4
) (
  input logic             clk,
  input logic             rst,
  divider_n_bit_if.slave  bus
);

  localparam int unsigned CntW = cnt_width(size);

  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [size-1:0] pr_q, pr_d;    // partial remainder
  logic [size-1:0] dvd_q, dvd_d;  // dividend, becomes the quotient
  logic [size-1:0] dvs_q, dvs_d;  // divisor magnitude
  logic [size-1:0] out_q, out_d;
  logic [size-1:0] rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;

  logic [size-1:0] step_rem;
  logic [size-1:0] step_dvd;

`ifdef DIVIDER_SIGNED_EN
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            ovf_pend_q, ovf_pend_d;
  logic [size-1:0] mag_a;
  logic [size-1:0] mag_b;
  logic            min_by_neg1;

  always_comb begin
    mag_a       = bus.in_a[size-1] ? -bus.in_a : bus.in_a;
    mag_b       = bus.in_b[size-1] ? -bus.in_b : bus.in_b;
    min_by_neg1 = (bus.in_a == {1'b1, {(size - 1){1'b0}}}) && (bus.in_b == '1);
  end
`endif

  divider_step #(
    .size (size)
  ) u_step (
    .part_rem      (pr_q),
    .dividend      (dvd_q),
    .divisor       (dvs_q),
    .next_rem      (step_rem),
    .next_dividend (step_dvd)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    out_d   = out_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
`ifdef DIVIDER_SIGNED_EN
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    ovf_pend_d = ovf_pend_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (bus.in_b == '0) begin
            state_d = StDone;
            out_d   = '1;
            rem_d   = bus.in_a;
            dbz_d   = 1'b1;
          end else begin
            state_d = StRun;
            cnt_d   = CntW'(size);
            pr_d    = '0;
`ifdef DIVIDER_SIGNED_EN
            dvd_d      = mag_a;
            dvs_d      = mag_b;
            q_neg_d    = bus.in_a[size-1] ^ bus.in_b[size-1];
            r_neg_d    = bus.in_a[size-1];
            ovf_pend_d = min_by_neg1;
`else
            dvd_d = bus.in_a;
            dvs_d = bus.in_b;
`endif
          end
        end
      end

      StRun: begin
        cnt_d = cnt_q - 1'b1;
        pr_d  = step_rem;
        dvd_d = step_dvd;
        // Last iteration: publish the result on the same edge that enters done.
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
`ifdef DIVIDER_SIGNED_EN
          // |MIN|/1 = 2^(size-1), whose negation wraps back to MIN.
          out_d = q_neg_q ? -step_dvd : step_dvd;
          rem_d = r_neg_q ? -step_rem : step_rem;
          ovf_d = ovf_pend_q;
`else
          out_d = step_dvd;
          rem_d = step_rem;
`endif
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pr_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef DIVIDER_SIGNED_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      ovf_pend_q <= 1'b0;
    end else begin
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      ovf_pend_q <= ovf_pend_d;
    end
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.out         = out_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = (state_q == StRun);
  assign bus.done        = (state_q == StDone);

endmodule

// File: tb/tb_divider_n_bit.sv
// Self-checking bench for divider_n_bit (size = 4): directed scenarios plus
// random operands checked against an arithmetic reference model.
module tb_divider_n_bit;

  localparam int unsigned Size    = 4;
  localparam int          MaxWait = 20;

  logic clk;
  logic rst;

  divider_n_bit_if #(.size(Size)) bus ();

  divider_n_bit #(
    .size (Size)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division following the stated result rules.
  task automatic model(input logic [3:0] a, input logic [3:0] b,
                       output logic [3:0] q, output logic [3:0] r,
                       output logic dz, output logic ov);
    int sa, sb;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 4'd0) begin
      q  = 4'hF;
      r  = a;
      dz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
      sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
      if (sa == -8 && sb == -1) begin
        q  = 4'b1000;
        r  = 4'd0;
        ov = 1'b1;
      end else begin
        q = 4'((sa / sb) & 15);
        r = 4'((sa % sb) & 15);
      end
`else
      sa = int'(a);
      sb = int'(b);
      q  = 4'(sa / sb);
      r  = 4'(sa % sb);
`endif
    end
  endtask

  // Called in cycle 1 of an operation; returns the cycle index where done is
  // seen (0 on timeout) and the number of busy cycles observed before it.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    for (int c = 1; c <= MaxWait; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = c;
        break;
      end
      step();
    end
  endtask

  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    bus.start = 1'b1;
    bus.in_a  = a;
    bus.in_b  = b;
    step();
    bus.start = 1'b0;
    bus.in_a  = $urandom_range(0, 15);
    bus.in_b  = $urandom_range(0, 15);
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] eq, er;
    logic       edz, eov;
    int         lat, bc;
    model(a, b, eq, er, edz, eov);
    launch(a, b);
    wait_done(lat, bc);
    chk({tag, "_latency"}, lat, edz ? 1 : Size + 1);
    chk({tag, "_busy_cycles"}, bc, edz ? 0 : Size);
    chk({tag, "_out"}, bus.out, eq);
    chk({tag, "_rem"}, bus.rem, er);
    chk({tag, "_dbz"}, bus.div_by_zero, edz);
    chk({tag, "_ovf"}, bus.overflow, eov);
    step();
    chk({tag, "_done_pulse"}, bus.done, 1'b0);
    chk({tag, "_out_hold"}, bus.out, eq);
  endtask

  initial begin
    int lat, bc, done_seen;
    logic [3:0] ra, rb;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in_a  = '0;
    bus.in_b  = '0;
    step();
    step();

    // Reset state
    chk("rst_out", bus.out, 4'd0);
    chk("rst_rem", bus.rem, 4'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_dbz", bus.div_by_zero, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    rst = 1'b0;
    step();

    run_op("u13d3", 4'd13, 4'd3);
    run_op("u7d0", 4'd7, 4'd0);

    // start re-pulsed in cycle 2 with new operands must be ignored
    launch(4'd13, 4'd3);            // now in cycle 1
    step();                         // cycle 2
    bus.start = 1'b1;
    bus.in_a  = 4'd15;
    bus.in_b  = 4'd4;
    step();                         // cycle 3
    bus.start = 1'b0;
    step();                         // cycle 4
    chk("repulse_busy_c4", bus.busy, 1'b1);
    step();                         // cycle 5
    chk("repulse_done_c5", bus.done, 1'b1);
    chk("repulse_out", bus.out, 4'd4);
    chk("repulse_rem", bus.rem, 4'd1);
    step();

    // rst in cycle 3 aborts the run
    launch(4'd13, 4'd3);            // cycle 1
    step();                         // cycle 2
    step();                         // cycle 3
    rst = 1'b1;
    step();                         // cycle 4
    rst = 1'b0;
    chk("abort_out", bus.out, 4'd0);
    chk("abort_rem", bus.rem, 4'd0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_dbz", bus.div_by_zero, 1'b0);
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    run_op("u9d2", 4'd9, 4'd2);

    // Back-to-back: new start held during the done cycle
    launch(4'd13, 4'd3);
    wait_done(lat, bc);
    chk("b2b_first_latency", lat, Size + 1);
    chk("b2b_first_out", bus.out, 4'd4);
    launch(4'd15, 4'd4);
    wait_done(lat, bc);
    chk("b2b_second_latency", lat, Size + 1);
    chk("b2b_second_busy", bc, Size);
    chk("b2b_second_out", bus.out, 4'd3);
    chk("b2b_second_rem", bus.rem, 4'd3);
    step();

    // Divide by zero right after a result, flags cleared by the next accept
    run_op("dz_again", 4'd11, 4'd0);
    run_op("after_dz", 4'd11, 4'd5);

`ifdef DIVIDER_SIGNED_EN
    run_op("s_m7d2", 4'b1001, 4'd2);
    run_op("s_m8dm1", 4'b1000, 4'b1111);
`endif

    // Random operands, roughly one divisor in eight is zero
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      run_op("rand", ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case stimulus itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
